regfile_write_arbiter: RTL and testbench

Shares the register file's single write port (rd/write_data/Reg_write) and its R31 link-save path (PC_in/OR_PC_in) between three requesters:
- writeback source A (ALU result)
- writeback source B (memory load)
- a link-save request (jal/jalr return address into R31)

---
 rtl/regfile_write_arbiter.sv | 99 +++++++++
 tb/tb_regfile_write_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: link save into R31 has top priority,
// ALU (A) and load (B) writebacks share the port round-robin.
module regfile_write_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req_a,
   input  logic [4:0]       rd_a,
   input  logic [31:0]      data_a,
   output logic             ack_a,
   input  logic             req_b,
   input  logic [4:0]       rd_b,
   input  logic [31:0]      data_b,
   output logic             ack_b,
   input  logic             link_req,
   input  logic [31:0]      link_pc,
   output logic             link_ack,
   output logic [4:0]       rd,
   output logic [31:0]      write_data,
   output logic             Reg_write,
   output logic [31:0]      PC_in,
   output logic             OR_PC_in,
   output logic [CNT_W-1:0] drop_count
);

   logic eff_a, eff_b, eff_l;
   logic elig_a, elig_b;
   logic gnt_a, gnt_b, gnt_l;
   logic rr_b;
   logic wr_en, drop_hit;
   logic [4:0] wr_rd;
   logic [31:0] wr_data;

   assign eff_a = req_a & ~ack_a;
   assign eff_b = req_b & ~ack_b;
   assign eff_l = link_req & ~link_ack;

   assign gnt_l = eff_l;

   // A/B writes to R31 would collide with the link save on the same port
   assign elig_a = eff_a & ~(gnt_l & (rd_a == 5'd31));
   assign elig_b = eff_b & ~(gnt_l & (rd_b == 5'd31));

   assign gnt_a = elig_a & (~elig_b | ~rr_b);
   assign gnt_b = elig_b & (~elig_a | rr_b);

   always_comb begin
      wr_en    = 1'b0;
      drop_hit = 1'b0;
      wr_rd    = rd_a;
      wr_data  = data_a;
      unique case (1'b1)
         gnt_a: begin
            wr_rd    = rd_a;
            wr_data  = data_a;
            wr_en    = (rd_a != 5'd0);
            drop_hit = (rd_a == 5'd0);
         end
         gnt_b: begin
            wr_rd    = rd_b;
            wr_data  = data_b;
            wr_en    = (rd_b != 5'd0);
            drop_hit = (rd_b == 5'd0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ack_a      <= 1'b0;
         ack_b      <= 1'b0;
         link_ack   <= 1'b0;
         rd         <= '0;
         write_data <= '0;
         Reg_write  <= 1'b0;
         PC_in      <= '0;
         OR_PC_in   <= 1'b0;
         drop_count <= '0;
         rr_b       <= 1'b0;
      end else begin
         ack_a     <= gnt_a;
         ack_b     <= gnt_b;
         link_ack  <= gnt_l;
         OR_PC_in  <= gnt_l;
         Reg_write <= wr_en;
         if (gnt_l) PC_in <= link_pc;
         if (wr_en) begin
            rd         <= wr_rd;
            write_data <= wr_data;
         end
         if (gnt_a | gnt_b) rr_b <= gnt_a;
         if (drop_hit && (drop_count != {CNT_W{1'b1}}))
            drop_count <= drop_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a narrow drop counter
// so saturation is reachable in a few cycles.
module tb_regfile_write_arbiter;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_a, req_b, link_req;
   logic [4:0]  rd_a, rd_b;
   logic [31:0] data_a, data_b, link_pc;
   logic        ack_a, ack_b, link_ack;
   logic [4:0]  rd;
   logic [31:0] write_data, PC_in;
   logic        Reg_write, OR_PC_in;
   logic [1:0]  drop_count;

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   regfile_write_arbiter #(.CNT_W(2)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_a(req_a), .rd_a(rd_a), .data_a(data_a), .ack_a(ack_a),
      .req_b(req_b), .rd_b(rd_b), .data_b(data_b), .ack_b(ack_b),
      .link_req(link_req), .link_pc(link_pc), .link_ack(link_ack),
      .rd(rd), .write_data(write_data), .Reg_write(Reg_write),
      .PC_in(PC_in), .OR_PC_in(OR_PC_in), .drop_count(drop_count)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic ra, input logic rb,
                          input logic rl, input logic rw, input logic orp);
      chk({tag, ".ack_a"}, {31'd0, ack_a}, {31'd0, ra});
      chk({tag, ".ack_b"}, {31'd0, ack_b}, {31'd0, rb});
      chk({tag, ".link_ack"}, {31'd0, link_ack}, {31'd0, rl});
      chk({tag, ".Reg_write"}, {31'd0, Reg_write}, {31'd0, rw});
      chk({tag, ".OR_PC_in"}, {31'd0, OR_PC_in}, {31'd0, orp});
   endtask

   initial begin
      reset_n = 1'b0;
      req_a = 0; req_b = 0; link_req = 0;
      rd_a = 0; rd_b = 0; data_a = 0; data_b = 0; link_pc = 0;

      // reset then idle
      tick; tick;
      chk_out("rst", 0, 0, 0, 0, 0);
      chk("rst.rd", {27'd0, rd}, 0);
      chk("rst.wd", write_data, 0);
      chk("rst.pc", PC_in, 0);
      chk("rst.drop", {30'd0, drop_count}, 0);
      reset_n = 1'b1;
      tick;
      chk_out("idle", 0, 0, 0, 0, 0);

      // single A write
      req_a = 1; rd_a = 5; data_a = 32'h0000_00AA;
      tick;
      chk_out("sa1", 1, 0, 0, 1, 0);
      chk("sa1.rd", {27'd0, rd}, 5);
      chk("sa1.wd", write_data, 32'hAA);
      req_a = 0;
      tick;
      chk_out("sa2", 0, 0, 0, 0, 0);
      chk("sa2.rd_hold", {27'd0, rd}, 5);
      chk("sa2.wd_hold", write_data, 32'hAA);

      // contention from reset
      reset_n = 0;
      req_a = 1; rd_a = 3; data_a = 32'h11;
      req_b = 1; rd_b = 4; data_b = 32'h22;
      tick;
      chk_out("ct0", 0, 0, 0, 0, 0);
      reset_n = 1;
      tick;
      chk_out("ct1", 1, 0, 0, 1, 0);
      chk("ct1.rd", {27'd0, rd}, 3);
      chk("ct1.wd", write_data, 32'h11);
      tick;
      chk_out("ct2", 0, 1, 0, 1, 0);
      chk("ct2.rd", {27'd0, rd}, 4);
      chk("ct2.wd", write_data, 32'h22);
      tick;
      chk_out("ct3", 1, 0, 0, 1, 0);
      chk("ct3.rd", {27'd0, rd}, 3);
      req_a = 0; req_b = 0;
      tick;
      chk_out("ct4", 0, 0, 0, 0, 0);

      // link with R31 conflict
      link_req = 1; link_pc = 32'h0040_0010;
      req_a = 1; rd_a = 31; data_a = 32'h77;
      tick;
      chk_out("lc1", 0, 0, 1, 0, 1);
      chk("lc1.pc", PC_in, 32'h0040_0010);
      link_req = 0;
      tick;
      chk_out("lc2", 1, 0, 0, 1, 0);
      chk("lc2.rd", {27'd0, rd}, 31);
      chk("lc2.wd", write_data, 32'h77);
      chk("lc2.pc_hold", PC_in, 32'h0040_0010);
      req_a = 0;

      // link with non-conflicting B
      link_req = 1; link_pc = 32'h0000_1234;
      req_b = 1; rd_b = 8; data_b = 32'h55;
      tick;
      chk_out("ln1", 0, 1, 1, 1, 1);
      chk("ln1.rd", {27'd0, rd}, 8);
      chk("ln1.wd", write_data, 32'h55);
      chk("ln1.pc", PC_in, 32'h0000_1234);
      link_req = 0; req_b = 0;

      // R0 drop
      req_a = 1; rd_a = 0; data_a = 32'h99;
      tick;
      chk_out("r0", 1, 0, 0, 0, 0);
      chk("r0.drop", {30'd0, drop_count}, 1);
      chk("r0.rd_hold", {27'd0, rd}, 8);
      req_a = 0;

      // reset while B pending
      req_b = 1; rd_b = 9; data_b = 32'h66;
      reset_n = 0;
      tick;
      chk_out("rm", 0, 0, 0, 0, 0);
      chk("rm.drop", {30'd0, drop_count}, 0);
      chk("rm.rd", {27'd0, rd}, 0);
      reset_n = 1;
      tick;
      chk_out("rm2", 0, 1, 0, 1, 0);
      chk("rm2.rd", {27'd0, rd}, 9);
      req_b = 0;
      tick;

      // drop counter saturation with both sources writing R0
      req_a = 1; rd_a = 0; req_b = 1; rd_b = 0;
      tick;
      chk_out("sat1", 1, 0, 0, 0, 0);
      chk("sat1.drop", {30'd0, drop_count}, 1);
      tick;
      chk_out("sat2", 0, 1, 0, 0, 0);
      chk("sat2.drop", {30'd0, drop_count}, 2);
      tick;
      chk("sat3.drop", {30'd0, drop_count}, 3);
      tick;
      chk("sat4.drop", {30'd0, drop_count}, 3);
      tick;
      chk("sat5.drop", {30'd0, drop_count}, 3);
      req_a = 0; req_b = 0;
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
